// File: rtl/useq_controller.sv
// Microprogrammed sequencer: picks the next micro-address (inc/jump/branch/map/call/ret/halt)
// and forwards the micro-ROM control word. Define USEQ_STACK_EN to build the return stack.
module useq_controller #(
    parameter int unsigned UADDR_W     = 7,
    parameter int unsigned CW_W        = 49,
    parameter int unsigned NCOND       = 4,
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned MAP_SHIFT   = 2,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned CS_W       = $clog2(NCOND),
    localparam int unsigned UW_W       = CW_W + 3 + CS_W + UADDR_W,
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        ir,
    input  logic [NCOND-1:0]   cond,
    input  logic               stall,
    input  logic               go,
    input  logic [UW_W-1:0]    uword,
    output logic [UADDR_W-1:0] uaddr,
    output logic [CW_W-1:0]    ops,
    output logic               halted,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JUMP = 3'd1,
        SEQ_BRT  = 3'd2,
        SEQ_BRF  = 3'd3,
        SEQ_MAP  = 3'd4,
        SEQ_CALL = 3'd5,
        SEQ_RET  = 3'd6,
        SEQ_HALT = 3'd7
    } seq_e;

    logic [UADDR_W-1:0] r_upc;
    logic [UADDR_W-1:0] w_upc_nxt;
    logic [UADDR_W-1:0] w_jaddr;
    logic [UADDR_W-1:0] w_inc;
    logic [UADDR_W-1:0] w_map;
    logic [CS_W-1:0]    w_csel;
    seq_e               w_seq;
    logic [CW_W-1:0]    w_ops_f;
    logic [OPC_W-1:0]   w_opc;
    logic               w_c;
    logic               w_halted;
    logic               w_unused_ir;

    // Micro-word field split, LSB first: jaddr, csel, seq, ops.
    assign w_jaddr  = uword[UADDR_W-1:0];
    assign w_csel   = uword[UADDR_W +: CS_W];
    assign w_seq    = seq_e'(uword[UADDR_W+CS_W +: 3]);
    assign w_ops_f  = uword[UW_W-1 -: CW_W];
    assign w_c      = cond[w_csel];
    assign w_inc    = r_upc + UADDR_W'(1);
    assign w_opc    = ir[15 -: OPC_W];
    assign w_map    = UADDR_W'(32'(w_opc) << MAP_SHIFT);
    assign w_halted = (w_seq == SEQ_HALT);
    assign w_unused_ir = &{1'b0, ir[15-OPC_W:0]};

`ifdef USEQ_STACK_EN
    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [UADDR_W-1:0] r_stack [2**PTR_W];
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;
    logic               w_push;
    logic               w_pop;
    logic               w_err_set;
    logic               w_full;
    logic               w_empty;
    logic [UADDR_W-1:0] w_top;

    assign w_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty = (r_depth == '0);
    assign w_top   = r_stack[PTR_W'(r_depth - DEPTH_W'(1))];
`endif

    // Next micro-address decode; stall leaves every piece of state untouched.
    always_comb begin
        w_upc_nxt = r_upc;
`ifdef USEQ_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
`endif
        if (!stall) begin
            case (w_seq)
                SEQ_NEXT: w_upc_nxt = w_inc;
                SEQ_JUMP: w_upc_nxt = w_jaddr;
                SEQ_BRT:  w_upc_nxt = w_c ? w_jaddr : w_inc;
                SEQ_BRF:  w_upc_nxt = w_c ? w_inc : w_jaddr;
                SEQ_MAP:  w_upc_nxt = w_map;
                SEQ_CALL: begin
`ifdef USEQ_STACK_EN
                    if (w_full) begin
                        w_upc_nxt = w_inc;
                        w_err_set = 1'b1;
                    end else begin
                        w_upc_nxt = w_jaddr;
                        w_push    = 1'b1;
                    end
`else
                    w_upc_nxt = w_jaddr;
`endif
                end
                SEQ_RET: begin
`ifdef USEQ_STACK_EN
                    if (w_empty) begin
                        w_upc_nxt = '0;
                        w_err_set = 1'b1;
                    end else begin
                        w_upc_nxt = w_top;
                        w_pop     = 1'b1;
                    end
`else
                    w_upc_nxt = w_inc;
`endif
                end
                SEQ_HALT: w_upc_nxt = go ? w_inc : r_upc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_upc <= '0;
        end else begin
            r_upc <= w_upc_nxt;
        end
    end

`ifdef USEQ_STACK_EN
    // Occupancy and sticky error; reset empties the stack even mid-CALL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Return-address storage needs no reset: entries are only read below r_depth.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[PTR_W'(r_depth)] <= w_inc;
        end
    end

    assign depth = r_depth;
    assign err   = r_err;
`else
    assign depth = '0;
    assign err   = 1'b0;
`endif

    assign uaddr  = r_upc;
    assign halted = w_halted;
    assign ops    = (reset || stall || (w_halted && !go)) ? '0 : w_ops_f;

endmodule
